// File: rtl/stp_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : stp_buffer_if
// Description : Bundles the sample-in and frame-out handshakes of the
//               serial-to-parallel frame buffer.
//   slave  modport : buffer view (takes samples, presents frames)
//   master modport : producer/consumer view (drives samples, takes frames)
//   in_valid/in_data/in_ready     serial sample stream
//   out_valid/out_data/out_ready  parallel frame, element k at [k*DATA_W +: DATA_W]
//   fill_count                    samples held in the write bank
//   overrun                       sticky dropped-sample flag
// Revision    : 1.0 - initial release
// ============================================================================
interface stp_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 48
);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic                      in_valid;
  logic [DATA_W-1:0]         in_data;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DEPTH*DATA_W-1:0]   out_data;
  logic [c_CNT_W-1:0]        fill_count;
  logic                      overrun;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, fill_count, overrun
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, fill_count, overrun
  );
endinterface
`default_nettype wire

// File: rtl/stp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stp_buffer
// Description : Double-buffered serial-to-parallel converter. Samples are
//               written into the write bank; a completed frame swaps into
//               the read bank and is offered as one wide word while the
//               next frame fills. Optional bit-reversed element placement.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   clr   : synchronous frame abort (ptr, full, valid, overrun cleared)
//   bus   : stp_buffer_if.slave (sample in, frame out, status)
// Revision    : 1.0 - initial release
// ============================================================================
module stp_buffer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 48,
  parameter int BIT_REV = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  stp_buffer_if.slave bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

  logic                    r_wr_sel;     // 0: write bank A, read bank B
  logic                    r_wr_full;    // write bank complete, waiting for swap
  logic                    r_out_valid;
  logic                    r_overrun;
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      w_wr_addr;
  logic                    w_accept;
  logic                    w_hs;
  logic                    w_last;
  logic [DEPTH*DATA_W-1:0] w_out_data;

  // clr masks both events so it wins over a same-cycle accept or handshake.
  assign w_accept = bus.in_valid & ~r_wr_full & ~clr;
  assign w_hs     = r_out_valid & bus.out_ready & ~clr;
  assign w_last   = w_accept & (r_wr_ptr == c_LAST);

  // Element address for the current sample.
  if (BIT_REV != 0) begin : g_bitrev
    for (genvar b = 0; b < c_PTR_W; b++) begin : g_bit
      assign w_wr_addr[b] = r_wr_ptr[c_PTR_W-1-b];
    end
  end else begin : g_natural
    assign w_wr_addr = r_wr_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_sel    <= 1'b0;
      r_wr_full   <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_wr_ptr    <= '0;
    end else if (clr) begin
      r_wr_full   <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_wr_ptr    <= '0;
    end else begin
      if (bus.in_valid & r_wr_full) begin
        r_overrun <= 1'b1;
      end
      if (w_accept) begin
        r_wr_ptr <= w_last ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_last) begin
        // Swap straight away if the read bank is free or being freed now;
        // otherwise park the finished frame and stall the input.
        if (!r_out_valid || w_hs) begin
          r_wr_sel    <= ~r_wr_sel;
          r_out_valid <= 1'b1;
        end else begin
          r_wr_full <= 1'b1;
        end
      end else if (w_hs) begin
        if (r_wr_full) begin
          // Parked frame becomes the new read frame; out_valid stays high.
          r_wr_sel  <= ~r_wr_sel;
          r_wr_full <= 1'b0;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_elem
    logic              w_we;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    assign w_we = w_accept & (w_wr_addr == c_PTR_W'(k));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_a <= '0;
        r_b <= '0;
      end else if (w_we) begin
        if (r_wr_sel) begin
          r_b <= bus.in_data;
        end else begin
          r_a <= bus.in_data;
        end
      end
    end

    // Read side is always the bank not being written.
    assign w_out_data[k*DATA_W +: DATA_W] = r_wr_sel ? r_a : r_b;
  end

  assign bus.out_data   = w_out_data;
  assign bus.in_ready   = ~r_wr_full;
  assign bus.out_valid  = r_out_valid;
  assign bus.overrun    = r_overrun;
  assign bus.fill_count = r_wr_full ? c_CNT_W'(DEPTH) : c_CNT_W'(r_wr_ptr);
endmodule
`default_nettype wire

// File: tb/tb_stp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stp_buffer
// Description : Self-checking bench for stp_buffer. One DEPTH=48 natural
//               instance and one DEPTH=8 bit-reversed instance share clk/rst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stp_buffer;
  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  stp_buffer_if #(.DATA_W(16), .DEPTH(48)) bus48 ();
  stp_buffer_if #(.DATA_W(16), .DEPTH(8))  bus8 ();

  stp_buffer #(.DATA_W(16), .DEPTH(48), .BIT_REV(0)) dut48 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus48)
  );

  stp_buffer #(.DATA_W(16), .DEPTH(8), .BIT_REV(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .bus (bus8)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        ordy;
    logic        c;
    logic        e_rdy;
    logic        e_ov;
    int          e_fill;
    logic        e_orun;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic v, input int d, input logic ordy, input logic c,
                              input logic e_rdy, input logic e_ov, input int e_fill,
                              input logic e_orun);
    vec_t r;
    r.v = v; r.d = 16'(d); r.ordy = ordy; r.c = c;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_fill = e_fill; r.e_orun = e_orun;
    tab.push_back(r);
  endfunction

  task automatic run_tab(input string tag);
    for (int i = 0; i < tab.size(); i++) begin
      bus48.in_valid  = tab[i].v;
      bus48.in_data   = tab[i].d;
      bus48.out_ready = tab[i].ordy;
      clr             = tab[i].c;
      cyc();
      chk($sformatf("%s[%0d].in_ready", tag, i), 64'(bus48.in_ready), 64'(tab[i].e_rdy));
      chk($sformatf("%s[%0d].out_valid", tag, i), 64'(bus48.out_valid), 64'(tab[i].e_ov));
      chk($sformatf("%s[%0d].fill_count", tag, i), 64'(bus48.fill_count), 64'(tab[i].e_fill));
      chk($sformatf("%s[%0d].overrun", tag, i), 64'(bus48.overrun), 64'(tab[i].e_orun));
    end
    bus48.in_valid  = 1'b0;
    bus48.out_ready = 1'b0;
    clr             = 1'b0;
    tab.delete();
  endtask

  task automatic check_frame(input string tag, input int base);
    int badk;
    logic [15:0] got;
    badk = -1;
    got  = '0;
    for (int k = 0; k < 48; k++) begin
      if (badk < 0 && bus48.out_data[k*16 +: 16] !== 16'(base + k)) begin
        badk = k;
        got  = bus48.out_data[k*16 +: 16];
      end
    end
    total++;
    if (badk >= 0) begin
      bad++;
      $display("FAIL %s: element %0d got %0d expected %0d", tag, badk, got, base + badk);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".in_ready"},    64'(bus48.in_ready), 64'd1);
    chk({tag, ".out_valid"},   64'(bus48.out_valid), 64'd0);
    chk({tag, ".fill_count"},  64'(bus48.fill_count), 64'd0);
    chk({tag, ".overrun"},     64'(bus48.overrun), 64'd0);
    chk({tag, ".out_data_nz"}, 64'(bus48.out_data !== '0), 64'd0);
    chk({tag, ".b8_out_valid"}, 64'(bus8.out_valid), 64'd0);
    chk({tag, ".b8_out_data_nz"}, 64'(bus8.out_data !== '0), 64'd0);
  endtask

  initial begin
    int exp8 [8];
    exp8 = '{0, 4, 2, 6, 1, 5, 3, 7};

    rst = 1'b1;
    clr = 1'b0;
    bus48.in_valid = 1'b0; bus48.in_data = '0; bus48.out_ready = 1'b0;
    bus8.in_valid  = 1'b0; bus8.in_data  = '0; bus8.out_ready  = 1'b0;
    repeat (2) cyc();
    check_reset("reset");
    rst = 1'b0;
    cyc();

    // Bit-reversed placement on the DEPTH=8 instance.
    for (int i = 0; i < 8; i++) begin
      bus8.in_valid = 1'b1;
      bus8.in_data  = 16'(i);
      cyc();
      chk($sformatf("bitrev[%0d].fill_count", i), 64'(bus8.fill_count), 64'((i < 7) ? i + 1 : 0));
      chk($sformatf("bitrev[%0d].out_valid", i), 64'(bus8.out_valid), 64'(i == 7));
    end
    bus8.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bitrev.elem%0d", k), 64'(bus8.out_data[k*16 +: 16]), 64'(exp8[k]));
    end
    bus8.out_ready = 1'b1;
    cyc();
    chk("bitrev.consumed", 64'(bus8.out_valid), 64'd0);
    bus8.out_ready = 1'b0;

    // Natural fill, consumer always ready.
    for (int i = 0; i < 48; i++) add(1, i, 1, 0, 1, i == 47, (i < 47) ? i + 1 : 0, 0);
    run_tab("fill");
    check_frame("fill.frame", 0);
    add(0, 0, 1, 0, 1, 0, 0, 0);
    run_tab("fill_drain");

    // Three back-to-back frames: input never stalls.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 48; i++) add(1, f * 100 + i, 1, 0, 1, i == 47, (i < 47) ? i + 1 : 0, 0);
      run_tab($sformatf("b2b%0d", f));
      check_frame($sformatf("b2b%0d.frame", f), f * 100);
    end
    add(0, 0, 1, 0, 1, 0, 0, 0);
    run_tab("b2b_drain");

    // Backpressure: 96 samples with no consumer, then one dropped sample.
    for (int i = 0; i < 48; i++) add(1, i, 0, 0, 1, i == 47, (i < 47) ? i + 1 : 0, 0);
    for (int i = 48; i < 95; i++) add(1, i, 0, 0, 1, 1, i - 47, 0);
    add(1, 95, 0, 0, 0, 1, 48, 0);
    add(1, 96, 0, 0, 0, 1, 48, 1);
    run_tab("bp");
    check_frame("bp.frame0", 0);
    add(0, 0, 1, 0, 1, 1, 0, 1);
    run_tab("bp_hs");
    check_frame("bp.frame1", 48);
    add(0, 0, 0, 0, 1, 1, 0, 1);
    run_tab("bp_hold");
    check_frame("bp.frame1_stable", 48);
    add(0, 0, 1, 0, 1, 0, 0, 1);
    run_tab("bp_drain");

    // Abort: 20 samples, then clr while in_valid is high.
    for (int i = 0; i < 20; i++) add(1, 700 + i, 1, 0, 1, 0, i + 1, 1);
    add(1, 9999, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 48; i++) add(1, 800 + i, 0, 0, 1, i == 47, (i < 47) ? i + 1 : 0, 0);
    run_tab("abort");
    check_frame("abort.frame", 800);

    // Completion of the next frame coincides with the handshake.
    for (int i = 0; i < 47; i++) add(1, 500 + i, 0, 0, 1, 1, i + 1, 0);
    run_tab("simul_pre");
    check_frame("simul.frame_held", 800);
    add(1, 547, 1, 0, 1, 1, 0, 0);
    run_tab("simul_edge");
    check_frame("simul.frame2", 500);
    add(0, 0, 1, 0, 1, 0, 0, 0);
    run_tab("simul_drain");

    // Reset mid-frame, asserted away from a clock edge.
    for (int i = 0; i < 10; i++) add(1, 300 + i, 0, 0, 1, 0, i + 1, 0);
    run_tab("rst_pre");
    rst = 1'b1;
    #2;
    check_reset("rst_mid");
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 48; i++) add(1, 900 + i, 1, 0, 1, i == 47, (i < 47) ? i + 1 : 0, 0);
    run_tab("post_rst");
    check_frame("post_rst.frame", 900);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stp_buffer.md
# stp_buffer

Parametrised double-buffered serial-to-parallel converter for the FFT input path. Accepts one DATA_W-bit sample per strobe and assembles frames of DEPTH samples. A completed frame is presented as one wide parallel word with a valid/ready handshake, so the next frame can be collected while the FFT core consumes the previous one. Optional bit-reversed placement feeds a decimation-in-time core directly.

## Interface
- DATA_W, 16, sample width in bits
- DEPTH, 48, samples per frame (≥2); must be a power of two when BIT_REV=1
- BIT_REV, 0, 0 = natural placement, 1 = sample j placed at element bitrev(j) over log2(DEPTH) bits
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous frame abort/clear, active-high
- in_valid  in  1  sample strobe; a sample is accepted when in_valid & in_ready
- in_data  in  DATA_W  serial sample
- in_ready  out  1  write bank can accept a sample
- out_valid  out  1  read bank holds a complete frame
- out_ready  in  1  consumer takes the frame when out_valid & out_ready
- out_data  out  DEPTH*DATA_W  frame; element k at bits [k*DATA_W +: DATA_W]
- fill_count  out  $clog2(DEPTH+1)  samples held in the write bank
- overrun  out  1  sticky: in_valid seen while in_ready=0

## Operation
- Two banks (A, B) of DEPTH×DATA_W registers, plus bank-select bit wr_sel; out_data always drives bank !wr_sel.
- State per write bank: wr_ptr (0..DEPTH-1), wr_full. Read bank state: out_valid.
- Accept: stores in_data at element wr_ptr (natural) or bitrev(wr_ptr) (BIT_REV=1); wr_ptr increments; fill_count = wr_ptr, or DEPTH when wr_full.
- Frame completion (accept at wr_ptr = DEPTH-1):
  - if out_valid=0, or the out handshake occurs at the same edge: toggle wr_sel, out_valid←1, wr_ptr←0, wr_full stays 0.
  - otherwise: wr_full←1, wr_ptr←0; no swap.
- Out handshake with wr_full=1: toggle wr_sel, wr_full←0, out_valid stays 1 (new frame).
- Out handshake with wr_full=0 and no completion at the same edge: out_valid←0.
- in_ready = !wr_full (combinational from registered state).
- in_valid & !in_ready: sample dropped, overrun←1; cleared only by clr or rst.
- clr: wr_ptr←0, wr_full←0, out_valid←0, overrun←0; wr_sel and bank contents unchanged; clr overrides any accept/handshake in the same cycle.
- Bank data is not cleared between frames; every element is rewritten before a frame is presented.

## Timing
- Reset (async assert, state held while rst=1): all bank registers 0, wr_sel 0, wr_ptr 0, wr_full 0; outputs out_valid 0, in_ready 1, out_data 0, fill_count 0, overrun 0.
- Throughput: one sample per cycle sustained when the consumer handshakes within DEPTH cycles of out_valid rising.
- Latency: last sample accepted at edge N → out_valid=1 and full frame on out_data from edge N.
- out_data is stable while out_valid=1 and no handshake occurs.
- Backpressure: wr_full rises at the edge accepting the 2·DEPTH-th un-consumed sample; in_ready falls at that edge; first handshake edge restores in_ready=1 for the following cycle.
- Reset asserted mid-frame: partial frame discarded; first post-reset sample lands at element 0.

## Test plan
- Natural fill: DATA_W=16, DEPTH=48, out_ready=1, in_data=0..47 on consecutive cycles → out_valid high one cycle after the 48th accept, element k = k, fill_count returns to 0.
- Back-to-back: 3 frames (0..47, 100..147, 200..247) with out_ready=1 throughout → in_ready never drops, three out_valid pulses with correct contents, overrun=0.
- Backpressure: out_ready=0, stream 96 samples then 1 more → in_ready=0 after sample 96, sample 97 dropped, overrun=1; assert out_ready one cycle → frame 0..47 then 48..95 presented, in_ready=1.
- Simultaneous event: 48th sample of frame 2 accepted on the same edge as frame-1 handshake → out_valid stays 1, out_data switches to frame 2, no stall.
- Bit reverse: DEPTH=8, BIT_REV=1, in_data=0..7 → out_data elements = 0,4,2,6,1,5,3,7.
- Abort/reset: 20 samples then clr (with in_valid=1 in the clr cycle) → fill_count=0, overrun=0, next 48 samples form a clean frame; repeat using rst mid-frame → all outputs at reset values.
